// File: rtl/riscv_v_alu_wb_fifo.sv
// riscv_v_alu_wb_fifo: in-order writeback buffer behind the vector ALU.
// Queues {result, zf, of, cf} and hands the entries to the register-file
// writeback port over a valid/ready handshake. Sticky ovf_err marks a drop.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_result/in_zf/
// in_of/in_cf from the ALU; out_valid/out_ready/out_result/out_zf/out_of/
// out_cf to writeback; count = occupancy; ovf_err = sticky drop flag.
// Optional: define RISCV_V_ALU_WB_FIFO_BYPASS_EN for an empty-buffer bypass.
module riscv_v_alu_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  parameter int FLAG_W = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [FLAG_W-1:0] in_zf,
  input  logic [FLAG_W-1:0] in_of,
  input  logic [FLAG_W-1:0] in_cf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [FLAG_W-1:0] out_zf,
  output logic [FLAG_W-1:0] out_of,
  output logic [FLAG_W-1:0] out_cf,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [FLAG_W-1:0] mem_zf     [DEPTH];
  logic [FLAG_W-1:0] mem_of     [DEPTH];
  logic [FLAG_W-1:0] mem_cf     [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic empty;
  logic bypass_take;
  logic push;
  logic pop;
  logic drop;

  function automatic logic [PTR_W-1:0] ptr_next(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_LAST) ptr_next = '0;
    else               ptr_next = p + 1'b1;
  endfunction

  // Readiness comes from registered count only; a pop never frees
  // a slot for a push in the same cycle.
  assign empty    = (count == '0);
  assign in_ready = (count != CNT_FULL);

`ifdef RISCV_V_ALU_WB_FIFO_BYPASS_EN
  // Empty buffer: the ALU result is visible at the output right away.
  // If writeback takes it, it never touches the storage.
  assign bypass_take = empty && in_valid && out_ready;

  always_comb begin
    out_valid  = 1'b0;
    out_result = '0;
    out_zf     = '0;
    out_of     = '0;
    out_cf     = '0;
    if (!empty) begin
      out_valid  = 1'b1;
      out_result = mem_result[rd_ptr];
      out_zf     = mem_zf[rd_ptr];
      out_of     = mem_of[rd_ptr];
      out_cf     = mem_cf[rd_ptr];
    end else if (in_valid) begin
      out_valid  = 1'b1;
      out_result = in_result;
      out_zf     = in_zf;
      out_of     = in_of;
      out_cf     = in_cf;
    end
  end
`else
  assign bypass_take = 1'b0;

  always_comb begin
    out_valid  = 1'b0;
    out_result = '0;
    out_zf     = '0;
    out_of     = '0;
    out_cf     = '0;
    if (!empty) begin
      out_valid  = 1'b1;
      out_result = mem_result[rd_ptr];
      out_zf     = mem_zf[rd_ptr];
      out_of     = mem_of[rd_ptr];
      out_cf     = mem_cf[rd_ptr];
    end
  end
`endif

  assign push = in_valid && in_ready && !bypass_take;
  assign pop  = !empty && out_ready;
  assign drop = in_valid && !in_ready;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_result[wr_ptr] <= in_result;
      mem_zf[wr_ptr]     <= in_zf;
      mem_of[wr_ptr]     <= in_of;
      mem_cf[wr_ptr]     <= in_cf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_v_alu_wb_fifo.sv
// tb_riscv_v_alu_wb_fifo: directed self-checking bench for the writeback
// buffer (DEPTH=4). Summary line: CHECKS <n> ERRORS <n>.
module tb_riscv_v_alu_wb_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 128;
  localparam int FLAG_W = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [FLAG_W-1:0] in_zf;
  logic [FLAG_W-1:0] in_of;
  logic [FLAG_W-1:0] in_cf;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_zf;
  logic [FLAG_W-1:0] out_of;
  logic [FLAG_W-1:0] out_cf;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;

  int checks = 0;
  int errors = 0;

  riscv_v_alu_wb_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .FLAG_W(FLAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zf     (in_zf),
    .in_of     (in_of),
    .in_cf     (in_cf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zf    (out_zf),
    .out_of    (out_of),
    .out_cf    (out_cf),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w};
  endfunction

  function automatic logic [FLAG_W-1:0] zfv(input int i);
    return 16'h0001 << (i % 16);
  endfunction

  function automatic logic [FLAG_W-1:0] ofv(input int i);
    return 16'h8000 >> (i % 16);
  endfunction

  function automatic logic [FLAG_W-1:0] cfv(input int i);
    return 16'(i * 3 + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input int i);
    in_valid  = 1'b1;
    in_result = word(i);
    in_zf     = zfv(i);
    in_of     = ofv(i);
    in_cf     = cfv(i);
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_result = '0;
    in_zf     = '0;
    in_of     = '0;
    in_cf     = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive_in(99);
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf_err got %b want 0", ovf_err);
    end
    checks++;
    if (out_result !== '0 || out_zf !== '0 || out_cf !== '0) begin
      errors++;
      $display("FAIL reset_out_zero got %h want 0", out_result);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 128'h1234;
    in_zf     = 16'h0001;
    in_of     = 16'h0000;
    in_cf     = 16'h0000;
`ifndef RISCV_V_ALU_WB_FIFO_BYPASS_EN
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_comb_path got %b want 0", out_valid);
    end
`endif
    tick();
    idle_in();
    #1;
    checks++;
    if (out_valid !== 1'b1 || count !== 1) begin
      errors++;
      $display("FAIL single_valid got v=%b c=%0d want v=1 c=1",
               out_valid, count);
    end
    checks++;
    if (out_result !== 128'h1234 || out_zf !== 16'h0001) begin
      errors++;
      $display("FAIL single_data got %h/%h want 1234/0001",
               out_result, out_zf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || out_result !== '0) begin
      errors++;
      $display("FAIL single_pop got c=%0d v=%b want c=0 v=0",
               count, out_valid);
    end
  endtask

  task automatic test_fill_drop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(10 + i);
      tick();
    end
    checks++;
    if (in_ready !== 1'b0 || count !== 4 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got r=%b c=%0d e=%b want r=0 c=4 e=0",
               in_ready, count, ovf_err);
    end
    drive_in(14);
    tick();
    idle_in();
    #1;
    checks++;
    if (ovf_err !== 1'b1 || count !== 4) begin
      errors++;
      $display("FAIL drop_flag got e=%b c=%0d want e=1 c=4",
               ovf_err, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== word(10 + i) ||
          out_zf !== zfv(10 + i) || out_of !== ofv(10 + i) ||
          out_cf !== cfv(10 + i)) begin
        errors++;
        $display("FAIL drain_%0d got %h want %h", i, out_result,
                 word(10 + i));
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 0 || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got c=%0d e=%b want c=0 e=1",
               count, ovf_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    drive_in(20);
    tick();
    drive_in(21);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_in(22 + i);
      #1;
      checks++;
      if (out_result !== word(20 + i) || out_cf !== cfv(20 + i)) begin
        errors++;
        $display("FAIL b2b_order_%0d got %h want %h", i, out_result,
                 word(20 + i));
      end
      tick();
      checks++;
      if (count !== 2) begin
        errors++;
        $display("FAIL b2b_count_%0d got %0d want 2", i, count);
      end
    end
    idle_in();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_result !== word(30 + i)) begin
        errors++;
        $display("FAIL b2b_tail_%0d got %h want %h", i, out_result,
                 word(30 + i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got c=%0d want 0", count);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(40 + i);
      tick();
    end
    drive_in(44);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ready_same got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (count !== 3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_count got c=%0d r=%b want c=3 r=1",
               count, in_ready);
    end
    out_ready = 1'b0;
    tick();
    idle_in();
    checks++;
    if (count !== 4) begin
      errors++;
      $display("FAIL fullpop_push got %0d want 4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_result !== word(41 + i)) begin
        errors++;
        $display("FAIL fullpop_drain_%0d got %h want %h", i,
                 out_result, word(41 + i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL fullpop_end got %0d want 0", count);
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    drive_in(50);
    tick();
    idle_in();
    checks++;
    if (count !== 1 || out_result !== word(50)) begin
      errors++;
      $display("FAIL empty_pop got c=%0d d=%h want c=1 d=%h",
               count, out_result, word(50));
    end
  endtask

`ifdef RISCV_V_ALU_WB_FIFO_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    in_valid  = 1'b1;
    in_result = 128'hBEEF;
    in_zf     = 16'h00F0;
    in_of     = '0;
    in_cf     = '0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 128'hBEEF ||
        out_zf !== 16'h00F0) begin
      errors++;
      $display("FAIL bypass_same got v=%b d=%h want v=1 d=beef",
               out_valid, out_result);
    end
    tick();
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL bypass_count got %0d want 0", count);
    end
    out_ready = 1'b0;
    tick();
    idle_in();
    #1;
    checks++;
    if (count !== 1 || out_result !== 128'hBEEF) begin
      errors++;
      $display("FAIL bypass_push got c=%0d d=%h want c=1 d=beef",
               count, out_result);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_in();
    test_reset();
    test_single_push();
    test_fill_drop();
    test_back_to_back();
    test_full_pop();
    test_empty_pop();
`ifdef RISCV_V_ALU_WB_FIFO_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
